// File: rtl/heater_pkg.sv
// heater_pkg: shared types, LFSR seed/polynomial table and the
// lowest-set-bit picker used by the heater bank sequencer.
package heater_pkg;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } seq_state_t;

  localparam logic [63:0] LFSR_SEED = 64'h9E37_79B9_7F4A_7C15;

  // Galois right-shift tap masks, maximal length for listed widths
  function automatic logic [63:0] lfsr_poly(input int w);
    logic [63:0] p;
    unique case (w)
      8:       p = 64'h0000_0000_0000_00B8;
      16:      p = 64'h0000_0000_0000_D008;
      24:      p = 64'h0000_0000_00E1_0000;
      32:      p = 64'h0000_0000_8020_0003;
      48:      p = 64'h0000_C000_0018_0000;
      64:      p = 64'hD800_0000_0000_0000;
      default: p = (64'd1 << (w - 1)) | 64'd1;
    endcase
    return p;
  endfunction

  // one-hot of the lowest set bit, zero if none
  function automatic logic [63:0] lowest_set(input logic [63:0] v);
    return v & (~v + 64'd1);
  endfunction

endpackage

// File: rtl/heater_bank_if.sv
// heater_bank_if: GPIO-side control/status bundle of the heater bank.
// master drives enable/duty/err_clear/inject_err, slave returns status.
interface heater_bank_if #(
  parameter int N_CH   = 32,
  parameter int DUTY_W = 8
);
  logic [N_CH-1:0]   enable;
  logic [DUTY_W-1:0] duty;
  logic [N_CH-1:0]   err_clear;
  logic [N_CH-1:0]   inject_err;
  logic [N_CH-1:0]   error;
  logic [N_CH-1:0]   granted;
  logic [N_CH-1:0]   active;
  logic              ramp_busy;

  modport master (
    output enable, duty, err_clear, inject_err,
    input  error, granted, active, ramp_busy
  );

  modport slave (
    input  enable, duty, err_clear, inject_err,
    output error, granted, active, ramp_busy
  );
endinterface

// File: rtl/heater_channel.sv
// heater_channel: dual LFSR load with self-check, inject hook, resync,
// sticky error latch and registered active flag (ports: run inputs, flags).
module heater_channel
  import heater_pkg::*;
#(
  parameter int LFSR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic granted,
  input  logic pwm_on,
  input  logic inject_err,
  input  logic err_clear,
  output logic error,
  output logic active
);

  localparam logic [63:0] POLY64 = lfsr_poly(LFSR_W);
  localparam logic [LFSR_W-1:0] POLY = POLY64[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED = LFSR_SEED[LFSR_W-1:0];

  function automatic logic [LFSR_W-1:0] step(
    input logic [LFSR_W-1:0] s
  );
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  logic              run;
  logic              mismatch;
  logic [LFSR_W-1:0] pri;
  logic [LFSR_W-1:0] shd;
  logic [LFSR_W-1:0] pri_nxt;
  logic [LFSR_W-1:0] shd_nxt;

  always_comb begin
    run      = granted & pwm_on;
    mismatch = (pri != shd);
    pri_nxt  = run ? step(pri) : pri;
    // a detected mismatch resyncs the shadow so it lasts one cycle
    shd_nxt  = mismatch ? pri_nxt : (run ? step(shd) : shd);
    shd_nxt[0] = shd_nxt[0] ^ inject_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri    <= SEED;
      shd    <= SEED;
      error  <= 1'b0;
      active <= 1'b0;
    end else begin
      pri    <= pri_nxt;
      shd    <= shd_nxt;
      error  <= mismatch | (error & ~err_clear);
      active <= run;
    end
  end

endmodule

// File: rtl/heater_bank.sv
// heater_bank: PWM throttle, staggered-start sequencer and N_CH heater
// channels; clk/rst_n plus the heater_bank_if slave bundle.
module heater_bank
  import heater_pkg::*;
#(
  parameter int N_CH     = 32,
  parameter int LFSR_W   = 32,
  parameter int DUTY_W   = 8,
  parameter int RAMP_DIV = 1024
) (
  input logic          clk,
  input logic          rst_n,
  heater_bank_if.slave bus
);

  localparam int CW = $clog2(RAMP_DIV);
  localparam logic [CW-1:0] WAIT_INIT = CW'(RAMP_DIV - 1);

  logic [DUTY_W-1:0] pwm_cnt;
  logic              pwm_on;
  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [CW-1:0]     wait_nxt;
  logic [N_CH-1:0]   granted;
  logic [N_CH-1:0]   grant_nxt;
  logic [N_CH-1:0]   pend;

  always_comb begin
    pwm_on    = (pwm_cnt < bus.duty);
    pend      = bus.enable & ~granted;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    // shutdown is immediate in every state
    grant_nxt = granted & bus.enable;
    unique case (state)
      S_IDLE: begin
        if (|pend) begin
          grant_nxt = grant_nxt
                    | N_CH'(lowest_set(64'(pend)));
          state_nxt = S_WAIT;
          wait_nxt  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = S_IDLE;
        else wait_nxt = wait_cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      state    <= S_IDLE;
      wait_cnt <= '0;
      granted  <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + DUTY_W'(1);
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      granted  <= grant_nxt;
    end
  end

  assign bus.granted   = granted;
  assign bus.ramp_busy = (state == S_WAIT);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    heater_channel #(
      .LFSR_W(LFSR_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .granted   (granted[i]),
      .pwm_on    (pwm_on),
      .inject_err(bus.inject_err[i]),
      .err_clear (bus.err_clear[i]),
      .error     (bus.error[i]),
      .active    (bus.active[i])
    );
  end

endmodule
